// File: rtl/direction_controller.sv
// -----------------------------------------------------------------------------
// direction_controller
//
// Turns raw player buttons into a registered movement direction for a
// tile-based game character. Buttons are synchronized and edge-detected. A new
// press becomes a one-hot "pending" turn request. On every move tick
// (evaluation edge), the pending request is applied if the current tile allows
// it. Otherwise the current direction is kept while it stays legal, or dropped
// to zero (stall) when it is blocked.
//
// Parameters
//   TICK_DIV   clk cycles per move tick (2..65535)
//   BUF_TICKS  move ticks a buffered turn request survives (1..255)
//
// Ports
//   clk             single clock, all state on its rising edge
//   rst             asynchronous, active-high reset
//   btn[3:0]        raw buttons, asynchronous to clk
//                   (bit0 left, bit1 right, bit2 up, bit3 down)
//   legal_moves[3:0] moves permitted at the current tile, same encoding
//   curr_direction[3:0] one-hot or all-zero direction for the position stage
//   move_tick       one-cycle pulse, first cycle an evaluation result is visible
//   stalled         high while the FSM is in STALLED
//
// Configuration macro
//   TURN_BUFFER_EN  when defined, a blocked request is retried on later ticks
//                   until it is applied or BUF_TICKS evaluations have passed.
//                   When undefined, a request lives for one evaluation only and
//                   no age counter is built.
// -----------------------------------------------------------------------------
module direction_controller #(
  parameter logic [15:0] TICK_DIV  = 16'd50000,
  parameter logic [7:0]  BUF_TICKS = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] legal_moves,
  output logic [3:0] curr_direction,
  output logic       move_tick,
  output logic       stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    STALLED = 2'd2
  } state_t;

  // Synchronizer and edge detector
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  btn_prev_q, btn_prev_d;

  // Tick timing
  logic [15:0] tick_q, tick_d;
  logic        move_tick_q, move_tick_d;

  // Request and direction
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  dir_q, dir_d;

`ifdef TURN_BUFFER_EN
  logic [7:0]  age_q, age_d;
  logic [7:0]  age_inc;
`endif

  state_t      state_q, state_d;

  // Combinational helpers
  logic [3:0]  btn_rise;
  logic [3:0]  req;
  logic        eval;
  logic        apply;
  logic        blocked;

  // Rising edges of the synchronized buttons, collapsed to a single one-hot
  // request. Left wins over right, right over up, and up over down.
  always_comb begin
    btn_rise = sync2_q & ~btn_prev_q;
    req      = 4'b0000;
    if (btn_rise[0]) begin
      req = 4'b0001;
    end else if (btn_rise[1]) begin
      req = 4'b0010;
    end else if (btn_rise[2]) begin
      req = 4'b0100;
    end else if (btn_rise[3]) begin
      req = 4'b1000;
    end
  end

  // Evaluation qualifiers. legal_moves is only meaningful on the evaluation
  // edge. apply and blocked are used only there.
  always_comb begin
    eval    = (tick_q == (TICK_DIV - 16'd1));
    apply   = |(pend_q & legal_moves);
    blocked = ~|(dir_q & legal_moves);
  end

  // Datapath next-state. At an evaluation, the pending request is applied
  // first. Failing that, the current direction is held or cleared. A request
  // that arrives in the same cycle always overwrites pend afterwards, so a
  // press landing on the evaluation edge waits for the following evaluation.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    btn_prev_d  = sync2_q;
    tick_d      = eval ? 16'd0 : (tick_q + 16'd1);
    move_tick_d = eval;
    pend_d      = pend_q;
    dir_d       = dir_q;
`ifdef TURN_BUFFER_EN
    age_d       = age_q;
    age_inc     = age_q + 8'd1;
`endif

    if (eval) begin
      if (apply) begin
        dir_d  = pend_q;
        pend_d = 4'b0000;
`ifdef TURN_BUFFER_EN
        age_d  = 8'd0;
`endif
      end else begin
        if (blocked) begin
          dir_d = 4'b0000;
        end
`ifdef TURN_BUFFER_EN
        // A blocked request is retried until it has aged BUF_TICKS
        // evaluations, then it is given up.
        if (pend_q != 4'b0000) begin
          if (age_inc >= BUF_TICKS) begin
            pend_d = 4'b0000;
            age_d  = 8'd0;
          end else begin
            age_d  = age_inc;
          end
        end
`else
        // Single-evaluation hold. The BUF_TICKS term is always true inside
        // its legal range and only keeps the parameter referenced here.
        if ((pend_q != 4'b0000) && (BUF_TICKS != 8'd0)) begin
          pend_d = 4'b0000;
        end
`endif
      end
    end

    if (req != 4'b0000) begin
      pend_d = req;
`ifdef TURN_BUFFER_EN
      age_d  = 8'd0;
`endif
    end
  end

  // FSM next-state. It changes only on evaluation edges.
  always_comb begin
    state_d = state_q;
    if (eval) begin
      unique case (state_q)
        IDLE: begin
          if (apply) begin
            state_d = MOVING;
          end
        end
        MOVING: begin
          if (!apply && blocked) begin
            state_d = STALLED;
          end
        end
        STALLED: begin
          if (apply) begin
            state_d = MOVING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All state registers. Reset clears any partial tick count and any pending
  // request, so the first evaluation comes a full TICK_DIV cycles after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      btn_prev_q  <= 4'b0000;
      tick_q      <= 16'd0;
      move_tick_q <= 1'b0;
      pend_q      <= 4'b0000;
      dir_q       <= 4'b0000;
`ifdef TURN_BUFFER_EN
      age_q       <= 8'd0;
`endif
      state_q     <= IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_prev_q  <= btn_prev_d;
      tick_q      <= tick_d;
      move_tick_q <= move_tick_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
`ifdef TURN_BUFFER_EN
      age_q       <= age_d;
`endif
      state_q     <= state_d;
    end
  end

  assign curr_direction = dir_q;
  assign move_tick      = move_tick_q;
  assign stalled        = (state_q == STALLED);

endmodule

// File: tb/tb_direction_controller.sv
// -----------------------------------------------------------------------------
// tb_direction_controller
//
// Self-checking bench for direction_controller (TICK_DIV=4, BUF_TICKS=3).
// The stimulus process drives one move-tick period at a time. For each
// period, it queues the hand-computed direction and stall flag expected at
// the end of that period. A separate monitor pops one entry for every
// move_tick pulse and compares it. The expectations for the turn-buffer
// sequence follow TURN_BUFFER_EN.
// -----------------------------------------------------------------------------
module tb_direction_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] legal_moves;
  logic [3:0] curr_direction;
  logic       move_tick;
  logic       stalled;

  typedef struct {
    int         id;
    logic [3:0] dir;
    logic       stl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef TURN_BUFFER_EN
  localparam logic [3:0] BUF_DIR = 4'b0100;
`else
  localparam logic [3:0] BUF_DIR = 4'b0001;
`endif

  always #5 clk = ~clk;

  direction_controller #(
    .TICK_DIV  (16'd4),
    .BUF_TICKS (8'd3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn            (btn),
    .legal_moves    (legal_moves),
    .curr_direction (curr_direction),
    .move_tick      (move_tick),
    .stalled        (stalled)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One move-tick period, entered on a negedge where the tick counter is 0.
  // A press at the start of the period is captured before this period's
  // evaluation. A late press (one cycle later) is captured on the evaluation
  // edge itself.
  task automatic applyStimulus(input int id, input logic [3:0] b,
                               input logic [3:0] lm, input bit late,
                               input logic [3:0] e_dir, input logic e_stl);
    exp_t e;
    e.id  = id;
    e.dir = e_dir;
    e.stl = e_stl;
    exp_q.push_back(e);
    legal_moves = lm;
    if (late) begin
      btn = 4'b0000;
      @(negedge clk);
      btn = b;
      repeat (3) @(negedge clk);
    end else begin
      btn = b;
      repeat (4) @(negedge clk);
    end
  endtask

  // Monitor: each move_tick presents one evaluation result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (move_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious move_tick", {31'd0, move_tick}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("P%0d curr_direction", e.id),
                      {28'd0, curr_direction}, {28'd0, e.dir});
          checkOutput($sformatf("P%0d stalled", e.id),
                      {31'd0, stalled}, {31'd0, e.stl});
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    btn         = 4'b0000;
    legal_moves = 4'b0000;
    repeat (3) @(negedge clk);
    checkOutput("reset curr_direction", {28'd0, curr_direction}, 32'd0);
    checkOutput("reset move_tick", {31'd0, move_tick}, 32'd0);
    checkOutput("reset stalled", {31'd0, stalled}, 32'd0);
    rst = 1'b0;

    // First press from IDLE, then hold
    applyStimulus(1,  4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b0);
    applyStimulus(2,  4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b0);
    // Reversal to right, then blocked -> stall, then recover left
    applyStimulus(3,  4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b0);
    applyStimulus(4,  4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1);
    applyStimulus(5,  4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(6,  4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b0);
    // Up requested while only left is legal for two ticks, legal on the 3rd
    applyStimulus(7,  4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(8,  4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(9,  4'b0100, 4'b0101, 1'b0, BUF_DIR, 1'b0);
    applyStimulus(10, 4'b0000, 4'b1111, 1'b0, BUF_DIR, 1'b0);
    applyStimulus(11, 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b0);
    applyStimulus(12, 4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b0);
    // Up blocked for three ticks: the request expires before it becomes legal
    applyStimulus(13, 4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(14, 4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(15, 4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(16, 4'b0100, 4'b0101, 1'b0, 4'b0001, 1'b0);
    applyStimulus(17, 4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b0);
    // Simultaneous right+up resolves to right
    applyStimulus(18, 4'b0110, 4'b1111, 1'b0, 4'b0010, 1'b0);
    applyStimulus(19, 4'b0000, 4'b1111, 1'b0, 4'b0010, 1'b0);
    // Press captured on the evaluation edge is applied one tick later
    applyStimulus(20, 4'b0001, 4'b1111, 1'b1, 4'b0010, 1'b0);
    applyStimulus(21, 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b0);
    applyStimulus(22, 4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b0);

    // Reset mid-count with a down request pending
    legal_moves = 4'b1111;
    btn         = 4'b1000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    btn = 4'b0000;
    #1;
    checkOutput("mid reset curr_direction", {28'd0, curr_direction}, 32'd0);
    checkOutput("mid reset move_tick", {31'd0, move_tick}, 32'd0);
    checkOutput("mid reset stalled", {31'd0, stalled}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.id  = 23;
      e.dir = 4'b0000;
      e.stl = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("post reset quiet cycle %0d move_tick", i),
                  {31'd0, move_tick}, 32'd0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
